// File: rtl/rr_pick.sv
`default_nettype none
// -----------------------------------------------------------------------------
// rr_pick : rotating-priority encoder, first set req at or after ptr (rev 1.0)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int PW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [PW-1:0]      pick,
  output logic               any
);

  int w_dist;
  int w_best;

  // Smallest wrapped distance from ptr wins; works for non-power-of-two counts.
  always_comb begin
    pick   = '0;
    any    = |req;
    w_best = NUM_SRC;
    w_dist = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req[i]) begin
        w_dist = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + NUM_SRC - int'(ptr));
        if (w_dist < w_best) begin
          w_best = w_dist;
          pick   = PW'(i);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_rr_drain.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fifo_rr_drain : round-robin burst drain of FWFT FIFOs to valid/ready (rev 1.0)
// -----------------------------------------------------------------------------
module fifo_rr_drain #(
  parameter int NUM_SRC = 4,
  parameter int DWIDTH  = 32,
  parameter int BURST   = 4,
  parameter int PW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_SRC-1:0]        src_empty,
  input  logic [NUM_SRC*DWIDTH-1:0] src_dout,
  output logic [NUM_SRC-1:0]        src_read,
  output logic [DWIDTH-1:0]         out_data,
  output logic [PW-1:0]             out_src,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam int              CW         = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [PW-1:0]   C_LAST_SRC = PW'(NUM_SRC - 1);
  localparam logic [CW-1:0]   C_LAST_CNT = CW'(BURST - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t              r_state;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_gnt;
  logic [CW-1:0]       r_cnt;

  logic                w_ld;
  logic                w_rd;
  logic                w_any;
  logic                w_sel_empty;
  logic [DWIDTH-1:0]   w_sel_data;
  logic [PW-1:0]       w_pick;
  logic [PW-1:0]       w_gnt_next;

  rr_pick #(.NUM_SRC(NUM_SRC), .PW(PW)) u_pick (
    .req  (~src_empty),
    .ptr  (r_ptr),
    .pick (w_pick),
    .any  (w_any)
  );

  always_comb begin
    w_sel_empty = 1'b1;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_gnt == PW'(i)) begin
        w_sel_empty = src_empty[i];
        w_sel_data  = src_dout[i*DWIDTH +: DWIDTH];
      end
    end
  end

  assign w_ld       = ~out_valid | out_ready;
  assign w_rd       = (r_state == GRANT) & enable & ~w_sel_empty & w_ld;
  assign w_gnt_next = (r_gnt == C_LAST_SRC) ? '0 : r_gnt + 1'b1;
  assign busy       = (r_state == GRANT) | out_valid;

  always_comb begin
    src_read = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_read[i] = w_rd & (r_gnt == PW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else begin
      if (w_rd) begin
        out_data  <= w_sel_data;
        out_src   <= r_gnt;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          // The pick cycle never pops; reads start in the following GRANT cycle.
          if (enable && w_any) begin
            r_gnt   <= w_pick;
            r_cnt   <= '0;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (!enable || w_sel_empty || (w_rd && (r_cnt == C_LAST_CNT))) begin
            r_state <= IDLE;
            r_ptr   <= w_gnt_next;
            r_cnt   <= '0;
          end else if (w_rd) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_drain.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_fifo_rr_drain : FIFO-queue source model plus per-source scoreboard (rev 1.0)
// -----------------------------------------------------------------------------
module tb_fifo_rr_drain;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int BU = 4;
  localparam int PW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              out_ready = 1'b0;
  logic [NS-1:0]     src_empty;
  logic [NS*DW-1:0]  src_dout;
  logic [NS-1:0]     src_read;
  logic [DW-1:0]     out_data;
  logic [PW-1:0]     out_src;
  logic              out_valid;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] fq  [NS][$];
  logic [DW-1:0] exq [NS][$];

  logic [NS-1:0] s_read, s_empty;
  logic          s_valid, s_ready, s_busy, s_xfer;
  logic [DW-1:0] s_data;
  logic [PW-1:0] s_src;

  fifo_rr_drain #(.NUM_SRC(NS), .DWIDTH(DW), .BURST(BU)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .src_empty (src_empty),
    .src_dout  (src_dout),
    .src_read  (src_read),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic void drive_src();
    for (int i = 0; i < NS; i++) begin
      src_empty[i]         = (fq[i].size() == 0);
      src_dout[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  endfunction

  task automatic push(input int s, input logic [DW-1:0] d);
    fq[s].push_back(d);
    exq[s].push_back(d);
    drive_src();
  endtask

  // Sample one cycle at the falling edge, then pop the FIFOs the DUT read.
  task automatic step();
    @(negedge clk);
    s_read  = src_read;
    s_empty = src_empty;
    s_valid = out_valid;
    s_ready = out_ready;
    s_busy  = busy;
    s_data  = out_data;
    s_src   = out_src;
    s_xfer  = out_valid & out_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++)
      if (s_read[i] === 1'b1 && fq[i].size() > 0) void'(fq[i].pop_front());
    drive_src();
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NS; i++) begin
      fq[i].delete();
      exq[i].delete();
    end
    drive_src();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; enable = 1'b0; out_ready = 1'b0;
    clear_queues();
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; out_ready = 1'b1;
    clear_queues();
    repeat (3) step();
    n_tests++;
    if ({s_valid, s_busy, s_read, s_src} !== '0 || s_data !== '0) begin
      n_fail++;
      $display("FAIL reset_values: valid=%b busy=%b read=%b src=%0d data=%h, required all zero",
               s_valid, s_busy, s_read, s_src, s_data);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      n_tests++;
      if ({s_valid, s_busy, s_read} !== '0) begin
        n_fail++;
        $display("FAIL idle_empty c=%0d: valid=%b busy=%b read=%b, required 0", c, s_valid, s_busy, s_read);
      end
    end
  endtask

  task automatic test_latency();
    int ov;
    logic [NS-1:0] exp_rd;
    logic exp_v;
    apply_reset();
    enable = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) push(2, DW'(32'hA0 + k));
    ov = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      exp_rd = (c inside {1, 2, 3, 4, 6, 7}) ? 4'b0100 : 4'b0000;
      exp_v  = (c inside {2, 3, 4, 5, 7, 8});
      n_tests++;
      if (s_read !== exp_rd) begin
        n_fail++;
        $display("FAIL latency_read c=%0d: got %b required %b", c, s_read, exp_rd);
      end
      n_tests++;
      if (s_valid !== exp_v) begin
        n_fail++;
        $display("FAIL latency_valid c=%0d: got %b required %b", c, s_valid, exp_v);
      end
      if (exp_v) begin
        n_tests++;
        if (s_data !== DW'(32'hA0 + ov) || s_src !== PW'(2)) begin
          n_fail++;
          $display("FAIL latency_data c=%0d: got %h/src%0d required %h/src2", c, s_data, s_src, 32'hA0 + ov);
        end
        ov++;
      end
    end
  endtask

  task automatic test_round_robin();
    int ntx, t0, t31;
    logic [DW-1:0] e;
    apply_reset();
    enable = 1'b1; out_ready = 1'b1;
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < 12; k++) push(s, DW'(s * 256 + k));
    ntx = 0; t0 = 0; t31 = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (s_xfer) begin
        if (ntx < 32) begin
          n_tests++;
          if (int'(s_src) !== (ntx / BU) % NS) begin
            n_fail++;
            $display("FAIL rr_order n=%0d: src %0d required %0d", ntx, s_src, (ntx / BU) % NS);
          end
        end
        n_tests++;
        if (exq[int'(s_src)].size() == 0) begin
          n_fail++;
          $display("FAIL rr_data n=%0d: got %h from src%0d, required nothing", ntx, s_data, s_src);
        end else begin
          e = exq[int'(s_src)].pop_front();
          if (s_data !== e) begin
            n_fail++;
            $display("FAIL rr_data n=%0d: got %h required %h", ntx, s_data, e);
          end
        end
        if (ntx == 0) t0 = c;
        if (ntx == 31) t31 = c;
        ntx++;
      end
    end
    n_tests++;
    if (ntx < 32 || (t31 - t0) != 38) begin
      n_fail++;
      $display("FAIL rr_bubbles: %0d words, span %0d cycles, required >=32 words span 38", ntx, t31 - t0);
    end
  endtask

  task automatic test_backpressure();
    int got;
    logic prev_stall;
    logic [DW-1:0] prev_data, e;
    logic [PW-1:0] prev_src;
    apply_reset();
    enable = 1'b1;
    for (int k = 0; k < 30; k++) push(1, DW'($urandom));
    got = 0; prev_stall = 1'b0; prev_data = '0; prev_src = '0;
    for (int c = 0; c < 220; c++) begin
      out_ready = (c < 100) ? (c % 3 == 0) : 1'($urandom_range(0, 1));
      step();
      if (s_valid && !s_ready) begin
        n_tests++;
        if (s_read !== '0) begin
          n_fail++;
          $display("FAIL bp_no_read c=%0d: read %b while stalled, required 0", c, s_read);
        end
      end
      if (prev_stall) begin
        n_tests++;
        if (!s_valid || s_data !== prev_data || s_src !== prev_src) begin
          n_fail++;
          $display("FAIL bp_hold c=%0d: valid=%b data=%h src=%0d required 1/%h/%0d",
                   c, s_valid, s_data, s_src, prev_data, prev_src);
        end
      end
      if (s_xfer) begin
        n_tests++;
        if (exq[int'(s_src)].size() == 0) begin
          n_fail++;
          $display("FAIL bp_data c=%0d: got %h, required no word", c, s_data);
        end else begin
          e = exq[int'(s_src)].pop_front();
          if (s_data !== e || s_src !== PW'(1)) begin
            n_fail++;
            $display("FAIL bp_data c=%0d: got %h/src%0d required %h/src1", c, s_data, s_src, e);
          end
        end
        got++;
      end
      prev_stall = s_valid & ~s_ready;
      prev_data  = s_data;
      prev_src   = s_src;
    end
    n_tests++;
    if (got != 30) begin
      n_fail++;
      $display("FAIL bp_count: got %0d words required 30", got);
    end
  endtask

  task automatic test_early_exit();
    int n;
    int exp_src[6] = '{0, 0, 3, 3, 3, 3};
    logic [DW-1:0] e;
    apply_reset();
    enable = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 2; k++) push(0, DW'(32'hE0 + k));
    for (int k = 0; k < 4; k++) push(3, DW'(32'hF0 + k));
    n = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (s_xfer) begin
        if (n < 6) begin
          n_tests++;
          if (int'(s_src) !== exp_src[n]) begin
            n_fail++;
            $display("FAIL early_src n=%0d: got %0d required %0d", n, s_src, exp_src[n]);
          end
        end
        n_tests++;
        if (exq[int'(s_src)].size() == 0) begin
          n_fail++;
          $display("FAIL early_data n=%0d: got %h, required no word", n, s_data);
        end else begin
          e = exq[int'(s_src)].pop_front();
          if (s_data !== e) begin
            n_fail++;
            $display("FAIL early_data n=%0d: got %h required %h", n, s_data, e);
          end
        end
        n++;
      end
    end
    n_tests++;
    if (n != 6) begin
      n_fail++;
      $display("FAIL early_count: got %0d words required 6", n);
    end
  endtask

  task automatic test_enable();
    int nrd, first;
    logic [NS-1:0] first_rd;
    apply_reset();
    enable = 1'b1; out_ready = 1'b1;
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < 8; k++) push(s, DW'($urandom));
    nrd = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (s_read != '0) nrd++;
      if (nrd == 2) break;
    end
    n_tests++;
    if (nrd != 2) begin
      n_fail++;
      $display("FAIL en_start: saw %0d reads required 2", nrd);
    end
    enable = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      n_tests++;
      if (s_read !== '0) begin
        n_fail++;
        $display("FAIL en_off_read c=%0d: got %b required 0", c, s_read);
      end
    end
    n_tests++;
    if (s_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL en_off_busy: got %b required 0", s_busy);
    end
    enable = 1'b1;
    first = -1; first_rd = '0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (s_read != '0 && first < 0) begin
        first = c;
        first_rd = s_read;
      end
    end
    n_tests++;
    if (first != 1 || first_rd !== 4'b0010) begin
      n_fail++;
      $display("FAIL en_resume: first read at %0d = %b, required 1 = 0010", first, first_rd);
    end
  endtask

  task automatic test_reset_stall();
    int found;
    apply_reset();
    enable = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) push(1, DW'($urandom));
    found = -1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (s_valid && found < 0) found = c;
    end
    n_tests++;
    if (found < 0 || s_read !== '0) begin
      n_fail++;
      $display("FAIL rst_stall_setup: valid at %0d read=%b, required valid and read 0", found, s_read);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    n_tests++;
    if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_data !== '0) begin
      n_fail++;
      $display("FAIL rst_stall: valid=%b busy=%b data=%h required 0/0/0", s_valid, s_busy, s_data);
    end
  endtask

  task automatic test_random();
    int run;
    logic prev_stall;
    logic [NS-1:0] prev_read;
    logic [DW-1:0] prev_data, e;
    apply_reset();
    enable = 1'b1;
    run = 0; prev_stall = 1'b0; prev_read = '0; prev_data = '0;
    for (int c = 0; c < 800; c++) begin
      if (c < 600)
        for (int s = 0; s < NS; s++)
          if ($urandom_range(0, 3) == 0 && fq[s].size() < 16) push(s, DW'($urandom));
      out_ready = (c >= 600) ? 1'b1 : ($urandom_range(0, 3) != 0);
      step();
      n_tests++;
      if ((s_read & s_empty) != '0 || !$onehot0(s_read)) begin
        n_fail++;
        $display("FAIL rnd_read c=%0d: read=%b empty=%b", c, s_read, s_empty);
      end
      if (s_valid && !s_ready) begin
        n_tests++;
        if (s_read !== '0) begin
          n_fail++;
          $display("FAIL rnd_stall_read c=%0d: got %b required 0", c, s_read);
        end
      end
      if (prev_stall) begin
        n_tests++;
        if (!s_valid || s_data !== prev_data) begin
          n_fail++;
          $display("FAIL rnd_hold c=%0d: got %h required %h", c, s_data, prev_data);
        end
      end
      if (s_read != '0) begin
        run = (s_read == prev_read) ? run + 1 : 1;
        n_tests++;
        if (run > BU) begin
          n_fail++;
          $display("FAIL rnd_burst c=%0d: run %0d required <= %0d", c, run, BU);
        end
      end else begin
        run = 0;
      end
      if (s_xfer) begin
        n_tests++;
        if (exq[int'(s_src)].size() == 0) begin
          n_fail++;
          $display("FAIL rnd_data c=%0d: got %h, required no word", c, s_data);
        end else begin
          e = exq[int'(s_src)].pop_front();
          if (s_data !== e) begin
            n_fail++;
            $display("FAIL rnd_data c=%0d src%0d: got %h required %h", c, s_src, s_data, e);
          end
        end
      end
      prev_stall = s_valid & ~s_ready;
      prev_data  = s_data;
      prev_read  = s_read;
    end
    for (int s = 0; s < NS; s++) begin
      n_tests++;
      if (exq[s].size() != 0) begin
        n_fail++;
        $display("FAIL rnd_drain src%0d: %0d words left required 0", s, exq[s].size());
      end
    end
  endtask

  initial begin
    drive_src();
    test_reset();
    test_latency();
    test_round_robin();
    test_backpressure();
    test_early_exit();
    test_enable();
    test_reset_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
